// File: rtl/veda_mem_arbiter_if.sv
// Bus bundle for veda_mem_arbiter: two requester ports, the memory port
// and the status outputs. The arbiter uses the slave view; the requesters
// and the memory model together use the master view.
interface veda_mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  // requester 0 (loader)
  logic              req0;
  logic              we0;
  logic              lock0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;
  // requester 1 (core load/store)
  logic              req1;
  logic              we1;
  logic              lock1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;
  // memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              owner;
  logic              lock_err;

  modport slave (
    input  req0, we0, lock0, addr0, wdata0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, lock1, addr1, wdata1,
    output gnt1, rvalid1, rdata1,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner, lock_err
  );

  modport master (
    output req0, we0, lock0, addr0, wdata0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, lock1, addr1, wdata1,
    input  gnt1, rvalid1, rdata1,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner, lock_err
  );
endinterface

// File: rtl/veda_mem_arbiter.sv
// Two-requester single-port memory arbiter. Round-robin between the loader
// (requester 0) and the core (requester 1) when both contend, with optional
// ownership locking bounded to LOCK_MAX cycles. A lock that runs out is
// released by force, flagged on the sticky lock_err output, and the holder
// must drop its lock request before it may lock again.
module veda_mem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic               clock,
  input  logic               reset_VM,
  veda_mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic               ptr_r, ptr_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               blk0_r, blk0_s;
  logic               blk1_r, blk1_s;
  logic               err_r, err_s;
  logic               owner_r, owner_s;
  logic               rvalid0_r, rvalid1_r;
  logic               gnt0_s, gnt1_s;

  // Grant decision: combinational from state and requests, forced low in reset.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset_VM) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (state_r)
        FREE: begin
          if (bus.req0 && bus.req1) begin
            if (ptr_r) begin
              gnt1_s = 1'b1;
            end else begin
              gnt0_s = 1'b1;
            end
          end else begin
            gnt0_s = bus.req0;
            gnt1_s = bus.req1;
          end
        end
        OWN0:    gnt0_s = bus.req0;
        OWN1:    gnt1_s = bus.req1;
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  // Next state, round-robin pointer, lock counter, re-lock blocking and error flag.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    // a block is lifted once the holder has been seen with its lock low
    blk0_s  = blk0_r & bus.lock0;
    blk1_s  = blk1_r & bus.lock1;
    err_s   = err_r;
    case (state_r)
      FREE: begin
        // contention only: the winner hands priority to the other side
        if (bus.req0 && bus.req1) begin
          ptr_s = gnt0_s;
        end else begin
          ptr_s = ptr_r;
        end
        if (gnt0_s && bus.lock0 && !blk0_r) begin
          state_s = OWN0;
          cnt_s   = {CNT_W{1'b0}};
        end else if (gnt1_s && bus.lock1 && !blk1_r) begin
          state_s = OWN1;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = FREE;
        end
      end
      OWN0: begin
        if (!bus.lock0) begin
          state_s = FREE;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
          state_s = FREE;
          cnt_s   = {CNT_W{1'b0}};
          err_s   = 1'b1;
          ptr_s   = 1'b1;
          blk0_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      OWN1: begin
        if (!bus.lock1) begin
          state_s = FREE;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
          state_s = FREE;
          cnt_s   = {CNT_W{1'b0}};
          err_s   = 1'b1;
          ptr_s   = 1'b0;
          blk1_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = FREE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Owner follows whichever requester transferred this cycle.
  always_comb begin
    owner_s = owner_r;
    if (gnt1_s) begin
      owner_s = 1'b1;
    end else if (gnt0_s) begin
      owner_s = 1'b0;
    end else begin
      owner_s = owner_r;
    end
  end

  // Control and status registers; reset cancels pending read returns and locks.
  always_ff @(posedge clock or posedge reset_VM) begin
    if (reset_VM) begin
      state_r   <= FREE;
      ptr_r     <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      blk0_r    <= 1'b0;
      blk1_r    <= 1'b0;
      err_r     <= 1'b0;
      owner_r   <= 1'b0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      cnt_r     <= cnt_s;
      blk0_r    <= blk0_s;
      blk1_r    <= blk1_s;
      err_r     <= err_s;
      owner_r   <= owner_s;
      rvalid0_r <= gnt0_s & ~bus.we0;
      rvalid1_r <= gnt1_s & ~bus.we1;
    end
  end

  // Memory-side mux: the granted requester drives the port, otherwise all zero.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    if (gnt0_s) begin
      bus.mem_we    = bus.we0;
      bus.mem_addr  = bus.addr0;
      bus.mem_wdata = bus.wdata0;
    end else if (gnt1_s) begin
      bus.mem_we    = bus.we1;
      bus.mem_addr  = bus.addr1;
      bus.mem_wdata = bus.wdata1;
    end else begin
      bus.mem_we    = 1'b0;
      bus.mem_addr  = {ADDR_W{1'b0}};
      bus.mem_wdata = {DATA_W{1'b0}};
    end
  end

  assign bus.gnt0     = gnt0_s;
  assign bus.gnt1     = gnt1_s;
  assign bus.mem_en   = gnt0_s | gnt1_s;
  assign bus.rvalid0  = rvalid0_r;
  assign bus.rvalid1  = rvalid1_r;
  // read data arrives one cycle after the strobe, so it is gated, not registered
  assign bus.rdata0   = rvalid0_r ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.rdata1   = rvalid1_r ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.owner    = owner_r;
  assign bus.lock_err = err_r;

endmodule

// File: tb/tb_veda_mem_arbiter.sv
// Directed bench for veda_mem_arbiter: a table of per-cycle input/expected
// records followed by a hand-written asynchronous reset sequence.
module tb_veda_mem_arbiter;

  localparam logic [31:0] WD0 = 32'h0000_0005;
  localparam logic [31:0] WD1 = 32'h0000_00B1;
  localparam logic [31:0] RB  = 32'hA000_0000;
  localparam int NV = 33;

  logic clock;
  logic reset_VM;

  veda_mem_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  veda_mem_arbiter #(.ADDR_W(5), .DATA_W(32), .LOCK_MAX(8)) dut (
    .clock    (clock),
    .reset_VM (reset_VM),
    .bus      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory model: returns a pattern derived from the address one cycle later
  always @(posedge clock) begin
    bus.mem_rdata <= RB | {27'd0, bus.mem_addr};
  end

  typedef struct {
    logic       rst;
    logic       r0, w0, l0;
    logic [4:0] a0;
    logic       r1, w1, l1;
    logic [4:0] a1;
    logic       g0, g1, mwe;
    logic [4:0] ma;
    logic [31:0] md;
    logic       rv0, rv1;
    logic [31:0] rd0, rd1;
    logic       own, lerr;
  } vec_t;

  vec_t vecs [NV];
  int   checks;
  int   errors;
  int   cur_row;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s row %0d: got %h, want %h", nm, cur_row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset_VM   = v.rst;
    bus.req0   = v.r0;
    bus.we0    = v.w0;
    bus.lock0  = v.l0;
    bus.addr0  = v.a0;
    bus.wdata0 = WD0;
    bus.req1   = v.r1;
    bus.we1    = v.w1;
    bus.lock1  = v.l1;
    bus.addr1  = v.a1;
    bus.wdata1 = WD1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cur_row = 0;
    bus.mem_rdata = 32'd0;
    //          rst    r0    w0    l0    a0      r1    w1    l1    a1       g0    g1    mwe   ma      md            rv0   rv1   rd0         rd1         own   lerr
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 5'd9,    1'b0, 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd3,  1'b0, 1'b0, 1'b0, 5'd0,    1'b1, 1'b0, 1'b1, 5'd3,  WD0,          1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,    1'b0, 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd4,  1'b1, 1'b0, 1'b0, 5'd9,    1'b1, 1'b0, 1'b0, 5'd4,  WD0,          1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd4,  1'b1, 1'b0, 1'b0, 5'd9,    1'b0, 1'b1, 1'b0, 5'd9,  WD1,          1'b1, 1'b0, 32'hA000_0004, 32'd0,   1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,    1'b0, 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b1, 32'd0,      32'hA000_0009, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd1,  1'b1, 1'b1, 1'b0, 5'd2,    1'b1, 1'b0, 1'b1, 5'd1,  WD0,          1'b0, 1'b0, 32'd0,      32'd0,      1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd1,  1'b1, 1'b1, 1'b1, 5'd2,    1'b0, 1'b1, 1'b1, 5'd2,  WD1,          1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd1,  1'b1, 1'b1, 1'b1, 5'd2,    1'b0, 1'b1, 1'b1, 5'd2,  WD1,          1'b0, 1'b0, 32'd0,      32'd0,      1'b1, 1'b0};
    vecs[9]  = vecs[8];
    vecs[10] = vecs[8];
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd1,  1'b1, 1'b1, 1'b0, 5'd2,    1'b0, 1'b1, 1'b1, 5'd2,  WD1,          1'b0, 1'b0, 32'd0,      32'd0,      1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd1,  1'b1, 1'b1, 1'b0, 5'd2,    1'b1, 1'b0, 1'b1, 5'd1,  WD0,          1'b0, 1'b0, 32'd0,      32'd0,      1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 5'd0,    1'b1, 1'b0, 1'b1, 5'd5,  WD0,          1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b0};
    for (int i = 14; i <= 21; i++) begin
      vecs[i] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd6,    1'b1, 1'b0, 1'b1, 5'd5,  WD0,          1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b0};
    end
    vecs[22] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 5'd6,    1'b0, 1'b1, 1'b1, 5'd6,  WD1,          1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b1};
    vecs[23] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 5'd6,    1'b1, 1'b0, 1'b1, 5'd5,  WD0,          1'b0, 1'b0, 32'd0,      32'd0,      1'b1, 1'b1};
    vecs[24] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 5'd0,    1'b1, 1'b0, 1'b1, 5'd5,  WD0,          1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b1};
    vecs[25] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 5'd6,    1'b0, 1'b1, 1'b1, 5'd6,  WD1,          1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b1};
    vecs[26] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 5'd0,    1'b1, 1'b0, 1'b1, 5'd7,  WD0,          1'b0, 1'b0, 32'd0,      32'd0,      1'b1, 1'b1};
    vecs[27] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 5'd8,    1'b0, 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b1};
    vecs[28] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 5'd8,    1'b0, 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b1};
    vecs[29] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd8,    1'b0, 1'b1, 1'b0, 5'd8,  WD1,          1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b1};
    vecs[30] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 5'd11,   1'b0, 1'b0, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b0};
    vecs[31] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 5'd11,   1'b1, 1'b0, 1'b0, 5'd10, WD0,          1'b0, 1'b0, 32'd0,      32'd0,      1'b0, 1'b0};
    vecs[32] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,    1'b0, 1'b0, 1'b0, 5'd0,  32'd0,        1'b1, 1'b0, 32'hA000_000A, 32'd0,   1'b0, 1'b0};

    // one record per clock cycle: drive after the edge, check mid-cycle
    for (int i = 0; i < NV; i++) begin
      cur_row = i;
      drive(vecs[i]);
      @(negedge clock);
      chk("gnt0",      32'(bus.gnt0),      32'(vecs[i].g0));
      chk("gnt1",      32'(bus.gnt1),      32'(vecs[i].g1));
      chk("mem_en",    32'(bus.mem_en),    32'(vecs[i].g0 | vecs[i].g1));
      chk("mem_we",    32'(bus.mem_we),    32'(vecs[i].mwe));
      chk("mem_addr",  32'(bus.mem_addr),  32'(vecs[i].ma));
      chk("mem_wdata", bus.mem_wdata,      vecs[i].md);
      chk("rvalid0",   32'(bus.rvalid0),   32'(vecs[i].rv0));
      chk("rvalid1",   32'(bus.rvalid1),   32'(vecs[i].rv1));
      chk("rdata0",    bus.rdata0,         vecs[i].rd0);
      chk("rdata1",    bus.rdata1,         vecs[i].rd1);
      chk("owner",     32'(bus.owner),     32'(vecs[i].own));
      chk("lock_err",  32'(bus.lock_err),  32'(vecs[i].lerr));
      @(posedge clock);
      #1;
    end

    // hand sequence: lock taken, then an asynchronous reset pulse mid-cycle
    cur_row = 100;
    reset_VM = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.lock0 = 1'b1; bus.addr0 = 5'd2;
    bus.req1 = 1'b0; bus.we1 = 1'b1; bus.lock1 = 1'b0; bus.addr1 = 5'd4;
    @(negedge clock);
    chk("hs_lock_gnt0", 32'(bus.gnt0), 32'd1);
    @(posedge clock);
    #1;
    cur_row = 101;
    bus.req0 = 1'b0;
    bus.req1 = 1'b1;
    @(negedge clock);
    chk("hs_own0_gnt1", 32'(bus.gnt1), 32'd0);
    chk("hs_own0_en",   32'(bus.mem_en), 32'd0);
    #1;
    reset_VM = 1'b1;
    #1;
    chk("hs_rst_gnt1",   32'(bus.gnt1),   32'd0);
    chk("hs_rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("hs_rst_mem_en", 32'(bus.mem_en), 32'd0);
    reset_VM = 1'b0;
    #1;
    // lock released by the reset: requester 1 is grantable at once
    chk("hs_post_gnt1",  32'(bus.gnt1),     32'd1);
    chk("hs_post_addr",  32'(bus.mem_addr), 32'd4);
    chk("hs_post_we",    32'(bus.mem_we),   32'd1);
    @(posedge clock);
    #1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0;
    @(negedge clock);
    cur_row = 102;
    chk("hs_owner",   32'(bus.owner),   32'd1);
    chk("hs_rvalid1", 32'(bus.rvalid1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
